// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// the opcodes that read rt in the ID stage, and the NOP encoding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    DMEM_WAIT  = 2'd3
  } pipe_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_INSTN = 32'h0000_0000;

  // Flush counter width; wide enough for the largest penalty reload (3).
  localparam int CNT_W = 3;

  // An instruction reads rt as a source only for these opcodes.
  function automatic logic op_uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in
// ID/EX and the source registers of the instruction held in IF/ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [15:0] instn_hi,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  output logic        load_use
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;

  assign opcode = instn_hi[15:10];
  assign rs     = instn_hi[9:5];
  assign rt     = instn_hi[4:0];

  // A load into $zero never creates a dependency; rt only counts when read.
  always_comb begin
    load_use = idex_mem_read && (idex_rt != 5'd0) &&
               ((idex_rt == rs) || (op_uses_rt(opcode) && (idex_rt == rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC / IF/ID / ID/EX sequencing for the 5-stage core.
// Handles load-use bubbles, redirect flushes, imem misses and dmem freezes.
// Optional build macro PIPE_CTRL_STATS_EN adds saturating event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ifid_instn,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        redirect,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
`endif
);

  localparam logic [CNT_W-1:0] PEN_RELOAD = CNT_W'(BRANCH_PENALTY - 1);

  pipe_state_e          state, state_nxt, saved_state, eff_state;
  logic [CNT_W-1:0]     cnt, cnt_nxt, saved_cnt, eff_cnt;
  logic                 load_use;
  logic                 unused_instn_lo;

  // Operand fields live in the upper half; the immediate/funct bits are not needed.
  assign unused_instn_lo = ^ifid_instn[15:0];

  hazard_detect u_hazard_detect (
    .instn_hi      (ifid_instn[31:16]),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .load_use      (load_use)
  );

  // While frozen, the interrupted state is evaluated as soon as dmem returns.
  always_comb begin
    eff_state = (state == DMEM_WAIT) ? saved_state : state;
    eff_cnt   = (state == DMEM_WAIT) ? saved_cnt   : cnt;
  end

  // State, flush counter and the context saved on entry to DMEM_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      saved_state <= RUN;
      saved_cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!dmem_ready && (state != DMEM_WAIT)) begin
        saved_state <= state;
        saved_cnt   <= cnt;
      end
    end
  end

  // Next state and control outputs, highest-priority condition first.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_nxt   = eff_state;
    cnt_nxt     = eff_cnt;

    if (!dmem_ready) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      state_nxt   = DMEM_WAIT;
      cnt_nxt     = cnt;
    end else if (redirect) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = PEN_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else if (eff_state == FLUSH) begin
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      if (eff_cnt <= CNT_W'(1)) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = eff_cnt - CNT_W'(1);
      end
    end else if (load_use && (eff_state == RUN)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nxt   = LOAD_STALL;
    end else if (!imem_ready) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else begin
      state_nxt = RUN;
    end

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  // Saturating per-cycle event counters; a bubble without flush is a load-use stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else begin
      if (idex_bubble && !ifid_flush && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
      if (pipe_freeze && (freeze_count != 32'hFFFF_FFFF))
        freeze_count <= freeze_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: two instances (BRANCH_PENALTY 2 and 3)
// share the same stimulus; expected control vectors go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [4:0]  rt;
    logic [31:0] instn;
    logic        redir;
    logic        imem;
    logic        dmem;
  } stim_t;

  typedef struct packed {
    logic [4:0] e2;
    logic [4:0] e3;
  } exp_t;

  // Vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] REDIR = 5'b10110;
  localparam logic [4:0] FLO   = 5'b10100;
  localparam logic [4:0] FRZ   = 5'b00001;
  localparam logic [4:0] RST   = 5'b00110;
  localparam logic [4:0] IMEM  = 5'b00100;

  localparam logic [31:0] ADD_RS8 = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] ADD_RS0 = 32'h0009_5020; // add $10,$0,$9
  localparam logic [31:0] BEQ_RT9 = 32'h10A9_0000; // beq $5,$9
  localparam logic [31:0] LW_RT9  = 32'h8C89_0000; // lw  $9,0($4)

  logic        clk;
  logic        rst_n;
  logic [31:0] ifid_instn;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        redirect;
  logic        imem_ready;
  logic        dmem_ready;
  logic        pw2, iw2, fl2, bb2, fz2;
  logic        pw3, iw3, fl3, bb3, fz3;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] sc2, fc2, zc2, sc3, fc3, zc3;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   exp_freeze = 0;

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ifid_instn(ifid_instn),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .redirect(redirect),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2),
    .idex_bubble(bb2), .pipe_freeze(fz2)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_count(sc2), .flush_count(fc2), .freeze_count(zc2)
`endif
  );

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ifid_instn(ifid_instn),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .redirect(redirect),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pw3), .ifid_write(iw3), .ifid_flush(fl3),
    .idex_bubble(bb3), .pipe_freeze(fz3)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_count(sc3), .flush_count(fc3), .freeze_count(zc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic mr, input logic [4:0] rt,
                               input logic [31:0] instn, input logic redir,
                               input logic imem, input logic dmem,
                               input logic rst);
    stim_t s;
    s.rst = rst; s.mr = mr; s.rt = rt; s.instn = instn;
    s.redir = redir; s.imem = imem; s.dmem = dmem;
    return s;
  endfunction

  function automatic exp_t E(input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    e.e2 = a; e.e3 = b;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rst_n         = s.rst;
    idex_mem_read = s.mr;
    idex_rt       = s.rt;
    ifid_instn    = s.instn;
    redirect      = s.redir;
    imem_ready    = s.imem;
    dmem_ready    = s.dmem;
  endtask

  task automatic test_reset();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(0,0,ADD_RS8,0,1,1,0), mk(0,0,ADD_RS8,0,1,1,0),
           mk(0,0,ADD_RS8,0,1,1,0), mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(RST,RST), E(RST,RST), E(RST,RST), E(NORM,NORM)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL reset[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(1,8,ADD_RS8,0,1,1,1), mk(1,8,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(1,0,ADD_RS0,0,1,1,1),
           mk(1,9,BEQ_RT9,0,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(1,9,LW_RT9,0,1,1,1),  mk(0,8,ADD_RS8,0,1,1,1)};
    ex = '{E(STALL,STALL), E(NORM,NORM), E(NORM,NORM), E(NORM,NORM),
           E(STALL,STALL), E(NORM,NORM), E(NORM,NORM), E(NORM,NORM)};
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL load_use[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(0,0,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(REDIR,REDIR), E(FLO,FLO), E(NORM,FLO), E(NORM,NORM),
           E(REDIR,REDIR), E(FLO,FLO), E(REDIR,REDIR), E(FLO,FLO),
           E(NORM,FLO), E(NORM,NORM)};
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL redirect[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_vs_load_use();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(1,8,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(1,8,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(REDIR,REDIR), E(FLO,FLO), E(NORM,FLO), E(STALL,STALL), E(NORM,NORM)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL redir_vs_lu[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imem_stall();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(0,0,ADD_RS8,0,0,1,1), mk(0,0,ADD_RS8,0,0,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(1,8,ADD_RS8,0,0,1,1),
           mk(0,0,ADD_RS8,0,0,1,1), mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(IMEM,IMEM), E(IMEM,IMEM), E(NORM,NORM), E(STALL,STALL),
           E(IMEM,IMEM), E(NORM,NORM)};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL imem[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dmem_freeze();
    stim_t st[11];
    exp_t  ex[11];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(0,0,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,0,1),
           mk(0,0,ADD_RS8,1,1,0,1), mk(0,0,ADD_RS8,0,1,0,1),
           mk(0,0,ADD_RS8,0,1,0,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1), mk(0,0,ADD_RS8,0,1,1,1),
           mk(1,8,ADD_RS8,0,1,0,1), mk(1,8,ADD_RS8,0,1,1,1),
           mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(REDIR,REDIR), E(FRZ,FRZ), E(FRZ,FRZ), E(FRZ,FRZ), E(FRZ,FRZ),
           E(FLO,FLO), E(NORM,FLO), E(NORM,NORM),
           E(FRZ,FRZ), E(STALL,STALL), E(NORM,NORM)};
    for (int i = 0; i < 11; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL dmem[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      if (st[i].rst) begin
        exp_flush += int'(cur.e3[2]); exp_freeze += int'(cur.e3[0]);
        if (cur.e3 == STALL) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef PIPE_CTRL_STATS_EN
  task automatic test_stats();
    checks++;
    if (sc3 !== 32'(exp_stall))
      $display("[TB] FAIL stall_count: got %0d want %0d", sc3, exp_stall);
    else passes++;
    checks++;
    if (fc3 !== 32'(exp_flush))
      $display("[TB] FAIL flush_count: got %0d want %0d", fc3, exp_flush);
    else passes++;
    checks++;
    if ((zc3 !== 32'(exp_freeze)) || (zc2 !== 32'(exp_freeze)))
      $display("[TB] FAIL freeze_count: bp2 got %0d bp3 got %0d want %0d", zc2, zc3, exp_freeze);
    else passes++;
    checks++;
    if (sc2 !== 32'(exp_stall))
      $display("[TB] FAIL stall_count_bp2: got %0d want %0d", sc2, exp_stall);
    else passes++;
  endtask
`endif

  task automatic test_reset_mid();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  cur;
    logic [4:0] o2, o3, m2, m3;
    st = '{mk(0,0,ADD_RS8,1,1,1,1), mk(0,0,ADD_RS8,0,1,1,0),
           mk(0,0,ADD_RS8,0,1,1,1), mk(0,0,ADD_RS8,1,1,1,1),
           mk(0,0,ADD_RS8,0,1,0,1), mk(0,0,ADD_RS8,0,1,0,0),
           mk(0,0,ADD_RS8,0,1,1,1)};
    ex = '{E(REDIR,REDIR), E(RST,RST), E(NORM,NORM), E(REDIR,REDIR),
           E(FRZ,FRZ), E(RST,RST), E(NORM,NORM)};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      cur = sb.pop_front();
      o2 = {pw2,iw2,fl2,bb2,fz2}; o3 = {pw3,iw3,fl3,bb3,fz3};
      m2 = {1'b0,cur.e2[2],3'b000}; m3 = {1'b0,cur.e3[2],3'b000};
      checks++;
      if (((o2 | m2) !== (cur.e2 | m2)) || ((o3 | m3) !== (cur.e3 | m3)))
        $display("[TB] FAIL reset_mid[%0d]: bp2 got %b want %b, bp3 got %b want %b", i, o2, cur.e2, o3, cur.e3);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(mk(0,0,ADD_RS8,0,1,1,0));
    @(posedge clk); #1;
    $display("[TB] starting pipeline_hazard_ctrl tests");
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_vs_load_use();
    test_imem_stall();
    test_dmem_freeze();
`ifdef PIPE_CTRL_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline controller that sequences the IF/ID pipeline register, PC and downstream stage registers of the 5-stage MIPS core. It detects load-use hazards, inserts bubbles and applies branch/jump redirect flushes. It freezes the whole pipeline while data memory is busy. It drives the enable and flush controls consumed by the PC, IF/ID, ID/EX and later stage registers.

## Interface
- BRANCH_PENALTY, 1: cycles of IF/ID flush after a taken redirect, including the redirect cycle; range 1..4.
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifid_instn  in  32  instruction currently held in IF/ID; rs=[25:21], rt=[20:16], opcode=[31:26].
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination register of the instruction in ID/EX.
- redirect  in  1  taken branch or jump resolved in EX this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- dmem_ready  in  1  data memory access completes or is idle this cycle.
- pc_write  out  1  PC loads its next value on this edge.
- ifid_write  out  1  IF/ID register captures new instruction, PC+4 and current PC.
- ifid_flush  out  1  IF/ID loads NOP (32'h0000_0000); overrides ifid_write.
- idex_bubble  out  1  ID/EX loads all-zero control (bubble).
- pipe_freeze  out  1  every stage register from ID/EX onward holds.

## Operation
- The state register is sequential. Outputs are combinational from state, flush counter and current inputs.
- States: RUN, LOAD_STALL, FLUSH, DMEM_WAIT.
- load_use = idex_mem_read & idex_rt!=0 & (idex_rt==rs | (uses_rt & idex_rt==rt)).
- uses_rt is true for opcode 0x00 (R-type), 0x04 (beq), 0x05 (bne) and 0x2B (sw).
- Priority within a cycle: !dmem_ready > redirect > load_use > !imem_ready > normal.
- Normal outputs: pc_write=1, ifid_write=1, other outputs 0.
- !dmem_ready, any state:
  - pc_write=0, ifid_write=0, flush=0, bubble=0, pipe_freeze=1.
  - Next state DMEM_WAIT. State and flush counter are saved and restored when dmem_ready returns.
  - DMEM_WAIT exits to the saved state on the first cycle with dmem_ready=1; that cycle is evaluated as the saved state.
- redirect in RUN, LOAD_STALL or FLUSH:
  - pc_write=1, ifid_flush=1, idex_bubble=1.
  - If BRANCH_PENALTY>1: next state FLUSH, counter=BRANCH_PENALTY-1. Otherwise stay in RUN.
- FLUSH: pc_write=1, ifid_flush=1, idex_bubble=0. Counter decrements each cycle and the state returns to RUN when the counter reaches 1. A new redirect reloads the counter.
- load_use in RUN: pc_write=0, ifid_write=0, idex_bubble=1, next state LOAD_STALL.
- LOAD_STALL: behaves as RUN with load_use masked, so no back-to-back stall on the same pair. Returns to RUN.
- !imem_ready with no higher-priority condition: pc_write=0, ifid_flush=1. State unchanged.

## Timing
- Zero-cycle latency from inputs to control outputs. State change is visible from the next cycle.
- Load-use costs exactly 1 bubble. A redirect costs BRANCH_PENALTY flushed IF/ID slots.
- While rst_n=0: state=RUN, counter=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
- Reset mid-FLUSH or mid-DMEM_WAIT discards the saved state and counter.
- redirect and load_use in the same cycle: redirect wins and load_use is discarded.

## Configuration
- PIPE_CTRL_STATS_EN defined: adds outputs stall_count[31:0], flush_count[31:0] and freeze_count[31:0]. They count, per cycle, load-use stalls, cycles with ifid_flush=1 and cycles with pipe_freeze=1. They saturate at 32'hFFFF_FFFF and reset to 0.
- PIPE_CTRL_STATS_EN undefined: these ports and counters do not exist. Control behaviour is identical.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW;
  - NOP_INSTN = 32'h0.
- One sub-module, hazard_detect: purely combinational load_use compare. Instantiated once.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> pc_write=0, ifid_flush=1, idex_bubble=1 throughout. After release with no hazards -> pc_write=1, ifid_write=1.
- Load-use: idex_mem_read=1, idex_rt=8, ifid_instn=add $t2,$t0,$t1 (rs=8) -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal. Same case with idex_rt=0 -> no stall.
- Redirect with BRANCH_PENALTY=2 -> ifid_flush=1 for exactly 2 cycles, idex_bubble=1 only in the first.
- redirect and load_use in the same cycle -> redirect outputs only, no LOAD_STALL entry.
- dmem_ready=0 for 4 cycles starting in the second FLUSH cycle (BRANCH_PENALTY=3) -> pipe_freeze=1 for 4 cycles, then 2 more flush cycles.
- With PIPE_CTRL_STATS_EN: after the above sequence -> stall_count=1, freeze_count=4.
